axi_read_arbiter: RTL and testbench
===================================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, the AR address width on all ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, the R data width on all ports.
REQ-003 SHALL have port clk, in, 1: single clock, all logic rising-edge.
REQ-004 SHALL have port rst, in, 1: synchronous, active-high reset.
REQ-005 SHALL have ports axi_ibus_araddr/arlen/arsize/arburst/arvalid, in, ADDR_WIDTH/8/3/2/1: I-side read address.
REQ-006 SHALL have port axi_ibus_arready, out, 1: I-side address accept.
REQ-007 SHALL have ports axi_ibus_rdata/rresp/rvalid/rlast, out, DATA_WIDTH/2/1/1: I-side read data.
REQ-008 SHALL have port axi_ibus_rready, in, 1: I-side data accept.
REQ-009 SHALL have a dbus port group (axi_dbus_*) with the same directions and widths as REQ-005..008.
REQ-010 SHALL have ports axi_mem_araddr/arlen/arsize/arburst/arvalid, out, ADDR_WIDTH/8/3/2/1: shared memory read address.
REQ-011 SHALL have port axi_mem_arready, in, 1.
REQ-012 SHALL have ports axi_mem_rdata/rresp/rvalid/rlast, in, DATA_WIDTH/2/1/1.
REQ-013 SHALL have port axi_mem_rready, out, 1.

Function
REQ-014 SHALL implement FSM states IDLE, ADDR, DATA.
REQ-015 IDLE: if any requester's arvalid=1, SHALL register the winner into grant_reg and move to ADDR next cycle; otherwise stay in IDLE.
REQ-016 ADDR: SHALL drive axi_mem_ar* from the granted master.
- SHALL route axi_mem_arready to the granted master's arready only; the other master's arready=0.
- On axi_mem_arvalid&&axi_mem_arready, SHALL move to DATA.
REQ-017 DATA: SHALL route axi_mem_rdata/rresp/rvalid/rlast to the granted master and drive axi_mem_rready from the granted master's rready.
- The non-granted master's rvalid SHALL be 0.
- On rvalid&&rready&&rlast, SHALL return to IDLE and update last_grant_reg.
REQ-018 axi_mem_arvalid SHALL be 0 outside ADDR; axi_mem_rready SHALL be 0 outside DATA; all arready outputs SHALL be 0 outside ADDR.
REQ-019 Grant SHALL be held for a whole burst; a new request SHALL NOT preempt an in-flight burst.
REQ-020 Arbitration latency SHALL be 1 cycle: a request seen in IDLE at cycle N presents axi_mem_arvalid at cycle N+1.
REQ-021 If both requesters are valid in the same IDLE cycle, the winner SHALL follow REQ-027/028.
REQ-022 A master deasserting arvalid while in ADDR is an AXI protocol violation; the behaviour is undefined and SHALL be flagged by the bench assertion.
REQ-023 A burst of arlen=0 (single beat, rlast on the first beat) SHALL be handled with no extra cycles.

Reset
REQ-024 While rst=1: state=IDLE, grant_reg=ibus, last_grant_reg=dbus, and all valid/ready outputs=0.
REQ-025 Reset mid-burst SHALL abandon the burst immediately; the memory is reset by the same rst.

Configuration
REQ-026 SHALL have macro AXI_ARB_ROUND_ROBIN_EN.
REQ-027 With AXI_ARB_ROUND_ROBIN_EN defined: on a simultaneous request, the master not in last_grant_reg SHALL win.
REQ-028 Without it: fixed priority, dbus beats ibus; last_grant_reg SHALL be removed.

Structure
REQ-029 The shared package SHALL hold the arb_state_t enum and the arb_master_t enum {ARB_IBUS, ARB_DBUS}.
REQ-030 SHALL be a single module with no sub-modules; the muxing SHALL be combinational on grant_reg.

Verification
REQ-031 Single ibus request, araddr=0x100, arlen=3, memory returns 4 beats -> ibus receives 4 beats, rlast on beat 4, FSM back in IDLE.
REQ-032 Simultaneous ibus and dbus requests, RR build, after reset -> ibus served first, then dbus; fixed build -> dbus first.
REQ-033 dbus request arrives during an ibus DATA phase -> dbus arready stays 0 until the ibus rlast beat, then dbus is granted 1 cycle later.
REQ-034 axi_mem_arready held low 5 cycles -> axi_mem_arvalid and araddr stay stable, and no R routing occurs.
REQ-035 ibus rready toggles during the burst -> axi_mem_rready mirrors it and no beat is lost or duplicated.
REQ-036 rst asserted during beat 2 of an arlen=7 burst -> next cycle all valids=0, state=IDLE, and a fresh request is served normally.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter_pkg
// Shared types and helpers for the two-master AXI read arbiter.
//
// Contents:
//   arb_state_t   - arbiter FSM states (IDLE / ADDR / DATA)
//   arb_master_t  - requester identifiers (ARB_IBUS / ARB_DBUS)
//   ARB_RESET_*   - grant values loaded while rst is high
//   arb_pick()    - winner selection for one IDLE cycle
//
// Build option: `AXI_ARB_ROUND_ROBIN_EN (consumed by axi_read_arbiter) picks
// round-robin arbitration. When it is left undefined, dbus has fixed priority.
// ---------------------------------------------------------------------------
package axi_read_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    ARB_IBUS = 1'b0,
    ARB_DBUS = 1'b1
  } arb_master_t;

  localparam arb_master_t ARB_RESET_GRANT = ARB_IBUS;
  localparam arb_master_t ARB_RESET_LAST  = ARB_DBUS;

  // A lone requester always wins. When both request in the same cycle,
  // round-robin gives the grant to whichever master was not served last.
  // Fixed priority always gives it to dbus.
  function automatic arb_master_t arb_pick(input logic        ibus_req,
                                           input logic        dbus_req,
                                           input arb_master_t last_grant,
                                           input logic        round_robin);
    arb_master_t pick;
    pick = ARB_IBUS;
    if (ibus_req && dbus_req) begin
      if (round_robin) begin
        pick = (last_grant == ARB_IBUS) ? ARB_DBUS : ARB_IBUS;
      end else begin
        pick = ARB_DBUS;
      end
    end else if (dbus_req) begin
      pick = ARB_DBUS;
    end
    return pick;
  endfunction

endpackage

// File: rtl/axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// axi_read_arbiter
// Shares one AXI read port (axi_mem_*) between an instruction master
// (axi_ibus_*) and a data master (axi_dbus_*). Only one burst is outstanding
// at a time. Once a master is granted, it keeps the grant until the last beat
// of its burst has been accepted.
//
// Parameters:
//   ADDR_WIDTH - AR address width on every port (default 32)
//   DATA_WIDTH - R data width on every port (default 32)
//
// Ports:
//   clk, rst               - single rising-edge clock, synchronous active-high reset
//   axi_ibus_ar*/arready   - I-side read address channel (arready is an output)
//   axi_ibus_r*/rready     - I-side read data channel (rready is an input)
//   axi_dbus_*             - D-side, same shape as the I-side
//   axi_mem_ar*/arready    - shared memory read address channel (arvalid is an output)
//   axi_mem_r*/rready      - shared memory read data channel (rready is an output)
//
// Build option: `AXI_ARB_ROUND_ROBIN_EN enables round-robin arbitration and the
// last_grant_reg history. Without it, dbus has fixed priority over ibus.
// ---------------------------------------------------------------------------
module axi_read_arbiter
  import axi_read_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] axi_ibus_araddr,
  input  logic [7:0]            axi_ibus_arlen,
  input  logic [2:0]            axi_ibus_arsize,
  input  logic [1:0]            axi_ibus_arburst,
  input  logic                  axi_ibus_arvalid,
  output logic                  axi_ibus_arready,
  output logic [DATA_WIDTH-1:0] axi_ibus_rdata,
  output logic [1:0]            axi_ibus_rresp,
  output logic                  axi_ibus_rvalid,
  output logic                  axi_ibus_rlast,
  input  logic                  axi_ibus_rready,

  input  logic [ADDR_WIDTH-1:0] axi_dbus_araddr,
  input  logic [7:0]            axi_dbus_arlen,
  input  logic [2:0]            axi_dbus_arsize,
  input  logic [1:0]            axi_dbus_arburst,
  input  logic                  axi_dbus_arvalid,
  output logic                  axi_dbus_arready,
  output logic [DATA_WIDTH-1:0] axi_dbus_rdata,
  output logic [1:0]            axi_dbus_rresp,
  output logic                  axi_dbus_rvalid,
  output logic                  axi_dbus_rlast,
  input  logic                  axi_dbus_rready,

  output logic [ADDR_WIDTH-1:0] axi_mem_araddr,
  output logic [7:0]            axi_mem_arlen,
  output logic [2:0]            axi_mem_arsize,
  output logic [1:0]            axi_mem_arburst,
  output logic                  axi_mem_arvalid,
  input  logic                  axi_mem_arready,
  input  logic [DATA_WIDTH-1:0] axi_mem_rdata,
  input  logic [1:0]            axi_mem_rresp,
  input  logic                  axi_mem_rvalid,
  input  logic                  axi_mem_rlast,
  output logic                  axi_mem_rready
);

  arb_state_t  state;
  arb_master_t grant_reg;
  arb_master_t winner;

  logic in_addr;
  logic in_data;
  logic grant_dbus;
  logic granted_arvalid;
  logic granted_rready;
  logic ar_fire;
  logic r_done;

`ifdef AXI_ARB_ROUND_ROBIN_EN
  arb_master_t last_grant_reg;

  // The master served most recently is the one that yields on a tie.
  assign winner = arb_pick(axi_ibus_arvalid, axi_dbus_arvalid, last_grant_reg, 1'b1);
`else
  // With fixed priority there is no history, so the tie rule ignores last_grant.
  assign winner = arb_pick(axi_ibus_arvalid, axi_dbus_arvalid, ARB_RESET_LAST, 1'b0);
`endif

  // Phase qualifiers. Both are forced low while rst is high, so every
  // valid/ready output drops in the same cycle that reset is asserted,
  // instead of waiting for the clock edge that moves the FSM back to IDLE.
  assign in_addr    = (state == ARB_ADDR) && !rst;
  assign in_data    = (state == ARB_DATA) && !rst;
  assign grant_dbus = (grant_reg == ARB_DBUS);

  assign ar_fire = axi_mem_arvalid && axi_mem_arready;
  assign r_done  = axi_mem_rvalid && axi_mem_rready && axi_mem_rlast;

  // Main arbiter FSM. IDLE latches the winner into grant_reg, so the memory
  // address phase starts one cycle after the request is seen. ADDR waits for
  // the memory to accept the address. DATA ends on the accepted rlast beat.
  // A burst is never preempted because the winner is only sampled in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB_IDLE;
      grant_reg <= ARB_RESET_GRANT;
`ifdef AXI_ARB_ROUND_ROBIN_EN
      last_grant_reg <= ARB_RESET_LAST;
`endif
    end else begin
      case (state)
        ARB_IDLE: begin
          if (axi_ibus_arvalid || axi_dbus_arvalid) begin
            grant_reg <= winner;
            state     <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (ar_fire) begin
            state <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (r_done) begin
            state <= ARB_IDLE;
`ifdef AXI_ARB_ROUND_ROBIN_EN
            last_grant_reg <= grant_reg;
`endif
          end
        end
        default: begin
          state <= ARB_IDLE;
        end
      endcase
    end
  end

  // Forward the granted master's address channel and handshake signals to
  // memory. The selection depends only on grant_reg. The phase gating is
  // applied separately below.
  always_comb begin
    axi_mem_araddr  = axi_ibus_araddr;
    axi_mem_arlen   = axi_ibus_arlen;
    axi_mem_arsize  = axi_ibus_arsize;
    axi_mem_arburst = axi_ibus_arburst;
    granted_arvalid = axi_ibus_arvalid;
    granted_rready  = axi_ibus_rready;
    if (grant_dbus) begin
      axi_mem_araddr  = axi_dbus_araddr;
      axi_mem_arlen   = axi_dbus_arlen;
      axi_mem_arsize  = axi_dbus_arsize;
      axi_mem_arburst = axi_dbus_arburst;
      granted_arvalid = axi_dbus_arvalid;
      granted_rready  = axi_dbus_rready;
    end
  end

  // Address handshake: memory sees arvalid only in ADDR, and only the granted
  // master sees memory's arready.
  assign axi_mem_arvalid  = in_addr && granted_arvalid;
  assign axi_ibus_arready = in_addr && !grant_dbus && axi_mem_arready;
  assign axi_dbus_arready = in_addr &&  grant_dbus && axi_mem_arready;

  // Data return: the data and response buses are shared by both masters.
  // Only the granted master sees rvalid and rlast, and only during DATA.
  // Memory's rready follows that same master.
  assign axi_mem_rready  = in_data && granted_rready;

  assign axi_ibus_rdata  = axi_mem_rdata;
  assign axi_ibus_rresp  = axi_mem_rresp;
  assign axi_ibus_rvalid = in_data && !grant_dbus && axi_mem_rvalid;
  assign axi_ibus_rlast  = in_data && !grant_dbus && axi_mem_rlast;

  assign axi_dbus_rdata  = axi_mem_rdata;
  assign axi_dbus_rresp  = axi_mem_rresp;
  assign axi_dbus_rvalid = in_data &&  grant_dbus && axi_mem_rvalid;
  assign axi_dbus_rlast  = in_data &&  grant_dbus && axi_mem_rlast;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_read_arbiter
// Self-checking bench for axi_read_arbiter. The bench plays both masters and
// the memory. A transaction-level reference model works out, for each cycle,
// which master owns the shared port and whether that master's address is
// still pending. From this it predicts every handshake output and the beats
// each master should receive.
// Respects `AXI_ARB_ROUND_ROBIN_EN for the tie-break expectation.
// ---------------------------------------------------------------------------
module tb_axi_read_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;

  logic [AW-1:0] axi_ibus_araddr, axi_dbus_araddr, axi_mem_araddr;
  logic [7:0]    axi_ibus_arlen, axi_dbus_arlen, axi_mem_arlen;
  logic [2:0]    axi_ibus_arsize, axi_dbus_arsize, axi_mem_arsize;
  logic [1:0]    axi_ibus_arburst, axi_dbus_arburst, axi_mem_arburst;
  logic          axi_ibus_arvalid, axi_dbus_arvalid, axi_mem_arvalid;
  logic          axi_ibus_arready, axi_dbus_arready, axi_mem_arready;
  logic [DW-1:0] axi_ibus_rdata, axi_dbus_rdata, axi_mem_rdata;
  logic [1:0]    axi_ibus_rresp, axi_dbus_rresp, axi_mem_rresp;
  logic          axi_ibus_rvalid, axi_dbus_rvalid, axi_mem_rvalid;
  logic          axi_ibus_rlast, axi_dbus_rlast, axi_mem_rlast;
  logic          axi_ibus_rready, axi_dbus_rready, axi_mem_rready;

  axi_read_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .axi_ibus_araddr(axi_ibus_araddr), .axi_ibus_arlen(axi_ibus_arlen),
    .axi_ibus_arsize(axi_ibus_arsize), .axi_ibus_arburst(axi_ibus_arburst),
    .axi_ibus_arvalid(axi_ibus_arvalid), .axi_ibus_arready(axi_ibus_arready),
    .axi_ibus_rdata(axi_ibus_rdata), .axi_ibus_rresp(axi_ibus_rresp),
    .axi_ibus_rvalid(axi_ibus_rvalid), .axi_ibus_rlast(axi_ibus_rlast),
    .axi_ibus_rready(axi_ibus_rready),
    .axi_dbus_araddr(axi_dbus_araddr), .axi_dbus_arlen(axi_dbus_arlen),
    .axi_dbus_arsize(axi_dbus_arsize), .axi_dbus_arburst(axi_dbus_arburst),
    .axi_dbus_arvalid(axi_dbus_arvalid), .axi_dbus_arready(axi_dbus_arready),
    .axi_dbus_rdata(axi_dbus_rdata), .axi_dbus_rresp(axi_dbus_rresp),
    .axi_dbus_rvalid(axi_dbus_rvalid), .axi_dbus_rlast(axi_dbus_rlast),
    .axi_dbus_rready(axi_dbus_rready),
    .axi_mem_araddr(axi_mem_araddr), .axi_mem_arlen(axi_mem_arlen),
    .axi_mem_arsize(axi_mem_arsize), .axi_mem_arburst(axi_mem_arburst),
    .axi_mem_arvalid(axi_mem_arvalid), .axi_mem_arready(axi_mem_arready),
    .axi_mem_rdata(axi_mem_rdata), .axi_mem_rresp(axi_mem_rresp),
    .axi_mem_rvalid(axi_mem_rvalid), .axi_mem_rlast(axi_mem_rlast),
    .axi_mem_rready(axi_mem_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Master-side state, index 0 = ibus, 1 = dbus
  bit          req_valid [2];
  logic [31:0] req_addr  [2];
  logic [7:0]  req_len   [2];
  logic [2:0]  req_size  [2];
  logic [1:0]  req_burst [2];
  bit          wait_data [2];
  logic [31:0] cur_addr  [2];
  logic [7:0]  cur_len   [2];
  int          beats_rx  [2];
  int          bursts_done [2];
  bit          rready_v  [2];
  int          req_rate = 0;
  bit          rand_knobs = 1'b0;

  // Reference model of shared-port ownership: -1 means nobody owns it
  int owner = -1;
  bit ar_pending = 1'b0;
  int last_served = 1;

  // Memory model
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr;
  logic [7:0]  mem_len;
  int          mem_beat = 0;
  bit          mem_arready_v = 1'b1;
  bit          mem_rvalid_v = 1'b1;

  // Observations taken from DUT outputs
  int          dut_served_q [$];
  int          ib_last_cyc = -1;
  int          db_ar_cyc = -1;
  bit          prev_ar_wait = 1'b0;
  logic [31:0] prev_araddr;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic int pick_winner();
    if (req_valid[0] && req_valid[1]) begin
`ifdef AXI_ARB_ROUND_ROBIN_EN
      return (last_served == 0) ? 1 : 0;
`else
      return 1;
`endif
    end
    return req_valid[1] ? 1 : 0;
  endfunction

  task automatic reset_model();
    owner = -1;
    ar_pending = 1'b0;
    last_served = 1;
    mem_busy = 1'b0;
    mem_beat = 0;
    prev_ar_wait = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      wait_data[i] = 1'b0;
    end
  endtask

  task automatic issue(input int m, input logic [31:0] addr, input logic [7:0] len);
    req_valid[m] = 1'b1;
    req_addr[m]  = addr;
    req_len[m]   = len;
    req_size[m]  = 3'd2;
    req_burst[m] = 2'd1;
  endtask

  // Drive every DUT input for this cycle from the master and memory models
  task automatic applyStimulus();
    if (rand_knobs) begin
      mem_arready_v = 1'($urandom_range(0, 1));
      mem_rvalid_v  = 1'($urandom_range(0, 1));
      rready_v[0]   = 1'($urandom_range(0, 1));
      rready_v[1]   = 1'($urandom_range(0, 1));
    end
    if (!rst) begin
      for (int m = 0; m < 2; m++) begin
        if (!req_valid[m] && !wait_data[m] && req_rate > 0 &&
            $urandom_range(0, 99) < req_rate) begin
          issue(m, $urandom & 32'hFFFF_FFFC, 8'($urandom_range(0, 7)));
        end
      end
    end
    axi_ibus_arvalid = req_valid[0];
    axi_ibus_araddr  = req_addr[0];
    axi_ibus_arlen   = req_len[0];
    axi_ibus_arsize  = req_size[0];
    axi_ibus_arburst = req_burst[0];
    axi_ibus_rready  = rready_v[0];
    axi_dbus_arvalid = req_valid[1];
    axi_dbus_araddr  = req_addr[1];
    axi_dbus_arlen   = req_len[1];
    axi_dbus_arsize  = req_size[1];
    axi_dbus_arburst = req_burst[1];
    axi_dbus_rready  = rready_v[1];
    axi_mem_arready  = mem_arready_v && !mem_busy;
    axi_mem_rvalid   = mem_busy && mem_rvalid_v;
    axi_mem_rdata    = mem_addr + 32'(mem_beat);
    axi_mem_rresp    = mem_beat[1:0];
    axi_mem_rlast    = mem_busy && (mem_beat == int'(mem_len));
  endtask

  // Compare outputs against the model, then advance the model to what the
  // coming clock edge should produce
  task automatic check_cycle();
    logic exp_arvalid, exp_rready, last_beat;
    logic exp_arready [2];
    logic exp_rvalid  [2];
    logic [31:0] obs_rdata;
    logic [1:0]  obs_rresp;
    logic        obs_rlast;
    exp_arvalid = 1'b0;
    exp_rready = 1'b0;
    last_beat = 1'b0;
    exp_arready[0] = 1'b0; exp_arready[1] = 1'b0;
    exp_rvalid[0] = 1'b0;  exp_rvalid[1] = 1'b0;
    if (!rst && owner >= 0) begin
      if (ar_pending) begin
        exp_arvalid = 1'b1;
        exp_arready[owner] = axi_mem_arready;
      end else begin
        exp_rvalid[owner] = axi_mem_rvalid;
        exp_rready = rready_v[owner];
      end
    end
    if (!rst && prev_ar_wait) begin
      checkOutput("ar_hold_valid", 64'(axi_mem_arvalid), 64'd1);
      checkOutput("ar_hold_addr", 64'(axi_mem_araddr), 64'(prev_araddr));
    end
    checkOutput("mem_arvalid", 64'(axi_mem_arvalid), 64'(exp_arvalid));
    checkOutput("ibus_arready", 64'(axi_ibus_arready), 64'(exp_arready[0]));
    checkOutput("dbus_arready", 64'(axi_dbus_arready), 64'(exp_arready[1]));
    checkOutput("mem_rready", 64'(axi_mem_rready), 64'(exp_rready));
    checkOutput("ibus_rvalid", 64'(axi_ibus_rvalid), 64'(exp_rvalid[0]));
    checkOutput("dbus_rvalid", 64'(axi_dbus_rvalid), 64'(exp_rvalid[1]));
    if (exp_arvalid) begin
      checkOutput("mem_araddr", 64'(axi_mem_araddr), 64'(req_addr[owner]));
      checkOutput("mem_arlen", 64'(axi_mem_arlen), 64'(req_len[owner]));
      checkOutput("mem_arsize", 64'(axi_mem_arsize), 64'(req_size[owner]));
      checkOutput("mem_arburst", 64'(axi_mem_arburst), 64'(req_burst[owner]));
    end
    if (!rst && owner >= 0 && !ar_pending && axi_mem_rvalid) begin
      obs_rdata = (owner == 0) ? axi_ibus_rdata : axi_dbus_rdata;
      obs_rresp = (owner == 0) ? axi_ibus_rresp : axi_dbus_rresp;
      obs_rlast = (owner == 0) ? axi_ibus_rlast : axi_dbus_rlast;
      checkOutput("beat_rdata", 64'(obs_rdata), 64'(cur_addr[owner] + 32'(beats_rx[owner])));
      checkOutput("beat_rresp", 64'(obs_rresp), 64'(beats_rx[owner][1:0]));
      checkOutput("beat_rlast", 64'(obs_rlast), 64'(beats_rx[owner] == int'(cur_len[owner])));
    end
    if (axi_ibus_rvalid === 1'b1 && axi_ibus_rlast === 1'b1 && axi_ibus_rready) begin
      dut_served_q.push_back(0);
      ib_last_cyc = cyc;
    end
    if (axi_dbus_rvalid === 1'b1 && axi_dbus_rlast === 1'b1 && axi_dbus_rready)
      dut_served_q.push_back(1);
    if (axi_dbus_arready === 1'b1 && db_ar_cyc < 0) db_ar_cyc = cyc;
    prev_ar_wait = !rst && axi_mem_arvalid === 1'b1 && axi_mem_arready === 1'b0;
    prev_araddr  = axi_mem_araddr;

    if (rst) begin
      reset_model();
    end else if (owner < 0) begin
      if (req_valid[0] || req_valid[1]) begin
        owner = pick_winner();
        ar_pending = 1'b1;
      end
    end else if (ar_pending) begin
      if (axi_mem_arready) begin
        ar_pending = 1'b0;
        req_valid[owner] = 1'b0;
        wait_data[owner] = 1'b1;
        cur_addr[owner] = req_addr[owner];
        cur_len[owner] = req_len[owner];
        beats_rx[owner] = 0;
        mem_busy = 1'b1;
        mem_addr = axi_mem_araddr;
        mem_len = axi_mem_arlen;
        mem_beat = 0;
      end
    end else if (axi_mem_rvalid && rready_v[owner]) begin
      last_beat = (mem_beat == int'(mem_len));
      beats_rx[owner]++;
      mem_beat++;
      if (last_beat) begin
        checkOutput("beat_count", 64'(beats_rx[owner]), 64'(cur_len[owner]) + 64'd1);
        wait_data[owner] = 1'b0;
        bursts_done[owner]++;
        last_served = owner;
        owner = -1;
        mem_busy = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic step_cycle();
    applyStimulus();
    #1;
    check_cycle();
    @(negedge clk);
  endtask

  task automatic run_until_quiet(input int bound, input string tag, output int n);
    bit quiet;
    n = 0;
    quiet = (owner < 0) && !req_valid[0] && !req_valid[1];
    while (!quiet && n < bound) begin
      step_cycle();
      n++;
      quiet = (owner < 0) && !req_valid[0] && !req_valid[1];
    end
    checks++;
    assert (quiet) else begin
      errors++;
      $error("[TB] FAIL %s_timeout observed=%0d cycles expected=completion", tag, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int first_served;
    for (int i = 0; i < 2; i++) begin
      req_addr[i] = '0; req_len[i] = '0; req_size[i] = '0; req_burst[i] = '0;
      rready_v[i] = 1'b1; bursts_done[i] = 0; beats_rx[i] = 0;
      cur_addr[i] = '0; cur_len[i] = '0;
    end
    mem_addr = '0;
    mem_len = '0;
    prev_araddr = '0;
    reset_model();

    // Reset: every valid/ready output low
    rst = 1'b1;
    repeat (3) step_cycle();
    rst = 1'b0;
    step_cycle();

    // Single ibus burst of 4 beats: 1 arbitration + 1 address + 4 data cycles
    issue(0, 32'h100, 8'd3);
    run_until_quiet(50, "single_ibus", n);
    checkOutput("single_ibus_cycles", 64'(n), 64'd6);
    checkOutput("single_ibus_bursts", 64'(bursts_done[0]), 64'd1);
    step_cycle();

    // Simultaneous requests straight after reset
    rst = 1'b1;
    step_cycle();
    rst = 1'b0;
    dut_served_q.delete();
    issue(0, 32'h200, 8'd1);
    issue(1, 32'h300, 8'd1);
    run_until_quiet(60, "tie", n);
`ifdef AXI_ARB_ROUND_ROBIN_EN
    first_served = 0;
`else
    first_served = 1;
`endif
    checkOutput("tie_served_count", 64'(dut_served_q.size()), 64'd2);
    if (dut_served_q.size() == 2) begin
      checkOutput("tie_first", 64'(dut_served_q[0]), 64'(first_served));
      checkOutput("tie_second", 64'(dut_served_q[1]), 64'(1 - first_served));
    end

    // dbus request arrives while ibus is in its data phase
    issue(0, 32'h400, 8'd3);
    repeat (3) step_cycle();
    db_ar_cyc = -1;
    ib_last_cyc = -1;
    issue(1, 32'h500, 8'd2);
    run_until_quiet(60, "no_preempt", n);
    checkOutput("no_preempt_gap", 64'(db_ar_cyc - ib_last_cyc), 64'd2);

    // Memory holds arready low for 5 cycles
    mem_arready_v = 1'b0;
    issue(0, 32'h600, 8'd0);
    repeat (6) step_cycle();
    mem_arready_v = 1'b1;
    run_until_quiet(20, "ar_stall", n);

    // ibus rready toggles every cycle during the burst
    issue(0, 32'h700, 8'd5);
    n = 0;
    while ((owner >= 0 || req_valid[0]) && n < 60) begin
      rready_v[0] = ~rready_v[0];
      step_cycle();
      n++;
    end
    rready_v[0] = 1'b1;
    checkOutput("toggle_done", 64'(owner < 0 && !req_valid[0]), 64'd1);

    // Reset during beat 2 of an 8-beat burst, followed by a single-beat request
    issue(0, 32'h800, 8'd7);
    n = 0;
    while (!(owner == 0 && !ar_pending && beats_rx[0] == 1) && n < 20) begin
      step_cycle();
      n++;
    end
    checkOutput("mid_burst_reached", 64'(beats_rx[0]), 64'd1);
    rst = 1'b1;
    step_cycle();
    rst = 1'b0;
    step_cycle();
    issue(0, 32'h900, 8'd0);
    run_until_quiet(20, "after_reset", n);
    checkOutput("single_beat_cycles", 64'(n), 64'd3);

    // Random traffic with random back-pressure, then drain
    rand_knobs = 1'b1;
    req_rate = 30;
    repeat (600) step_cycle();
    rand_knobs = 1'b0;
    req_rate = 0;
    mem_arready_v = 1'b1;
    mem_rvalid_v = 1'b1;
    rready_v[0] = 1'b1;
    rready_v[1] = 1'b1;
    run_until_quiet(200, "drain", n);
    step_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
